// File: rtl/knn_local_mem_1r1w_pipe_if.sv
// Bus bundle for the partialKnn simple-dual-port local buffer.
// The master drives the write and read ports. The slave (the buffer) returns
// read data, the valid strobe and the status flags.
interface knn_local_mem_1r1w_pipe_if #(
    parameter int DataWidth    = 256,
    parameter int AddressWidth = 11
);
    logic [AddressWidth-1:0]  wr_address;
    logic                     wr_ce;
    logic [DataWidth/8-1:0]   wr_be;
    logic [DataWidth-1:0]     wr_d;
    logic [AddressWidth-1:0]  rd_address;
    logic                     rd_ce;
    logic [DataWidth-1:0]     q;
    logic                     q_valid;
    logic                     init_done;
    logic                     oob_err;

    modport master (
        output wr_address, wr_ce, wr_be, wr_d, rd_address, rd_ce,
        input  q, q_valid, init_done, oob_err
    );

    modport slave (
        input  wr_address, wr_ce, wr_be, wr_d, rd_address, rd_ce,
        output q, q_valid, init_done, oob_err
    );
endinterface

// File: rtl/knn_local_mem_1r1w_pipe.sv
// Simple-dual-port local buffer for the partialKnn kernels.
// It has one byte-enabled write port and one pipelined read port. A collision
// mode is selectable. An optional post-reset engine zeroes every word.
// An out-of-range access is dropped or returns zero, and sets a sticky error flag.
module knn_local_mem_1r1w_pipe #(
    parameter int DataWidth    = 256,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int ReadLatency  = 2,
    parameter int WriteFirst   = 0,
    parameter int ClearOnReset = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    knn_local_mem_1r1w_pipe_if.slave  mem_if
);

    localparam int BeWidth = DataWidth / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t                  RESET_STATE = (ClearOnReset != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [AddressWidth:0]   ADDR_LIMIT  = (AddressWidth + 1)'(AddressRange);
    localparam logic [AddressWidth-1:0] LAST_ADDR   = AddressWidth'(AddressRange - 1);

    // Storage array. It is not reset, so it maps onto URAM/BRAM.
    logic [DataWidth-1:0] mem_array [AddressRange];

    // Control state
    state_t                  state_q,     state_d;
    logic [AddressWidth-1:0] clr_cnt_q,   clr_cnt_d;
    logic                    init_done_q, init_done_d;
    logic                    oob_err_q,   oob_err_d;

    // Output stage
    logic                    q_valid_q,   q_valid_d;
    logic [DataWidth-1:0]    q_q,         q_d;

    // Request decode
    logic                    run;
    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_fire;
    logic                    collide;

    // Array write port, shared by the clear engine and the user
    logic                    mem_we;
    logic [AddressWidth-1:0] mem_waddr;
    logic [BeWidth-1:0]      mem_wbe;
    logic [DataWidth-1:0]    mem_wdata;

    // Read stage 0: the word captured at the request edge
    logic [DataWidth-1:0]    rd_word;
    logic [DataWidth-1:0]    rd_merged;
    logic                    rd_vld_p0;
    logic [DataWidth-1:0]    rd_data_p0;

    // Input to the output stage (stage 0 directly, or the last middle stage)
    logic                    tail_vld;
    logic [DataWidth-1:0]    tail_data;

    // Decode user requests. User requests are accepted only once the clear engine has finished.
    always_comb begin
        run         = (state_q == ST_RUN);
        wr_in_range = ({1'b0, mem_if.wr_address} < ADDR_LIMIT);
        rd_in_range = ({1'b0, mem_if.rd_address} < ADDR_LIMIT);
        wr_fire     = run && mem_if.wr_ce && wr_in_range;
        collide     = wr_fire && rd_in_range && mem_if.rd_ce
                      && (mem_if.wr_address == mem_if.rd_address);
    end

    // Clear-engine sequencing and status flags. The sticky error flag is frozen during clear.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = (state_q == ST_RUN);
        oob_err_d   = oob_err_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end
        end else begin
            if ((mem_if.wr_ce && !wr_in_range) || (mem_if.rd_ce && !rd_in_range)) begin
                oob_err_d = 1'b1;
            end
        end
    end

    // Control registers. Reset restarts the clear engine from word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            oob_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            oob_err_q   <= oob_err_d;
        end
    end

    // Select the array write source. The clear engine owns the port while it runs.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = mem_if.wr_address;
        mem_wbe   = mem_if.wr_be;
        mem_wdata = mem_if.wr_d;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wbe   = '1;
            mem_wdata = '0;
        end else if (wr_fire) begin
            mem_we    = 1'b1;
        end
    end

    // Byte-enabled array write
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BeWidth; i++) begin
                if (mem_wbe[i]) begin
                    mem_array[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Stage 0. Read the array and apply the collision mode. An out-of-range read returns zero.
    always_comb begin
        rd_word   = mem_array[mem_if.rd_address];
        rd_merged = rd_word;
        for (int i = 0; i < BeWidth; i++) begin
            if (mem_if.wr_be[i]) begin
                rd_merged[8*i +: 8] = mem_if.wr_d[8*i +: 8];
            end
        end
        rd_vld_p0  = run && mem_if.rd_ce;
        rd_data_p0 = '0;
        if (rd_in_range) begin
            rd_data_p0 = ((WriteFirst != 0) && collide) ? rd_merged : rd_word;
        end
    end

    generate
        if (ReadLatency > 1) begin : g_mid
            localparam int MidDepth = ReadLatency - 1;

            logic [MidDepth-1:0]  rd_vld_pn_q,  rd_vld_pn_d;
            logic [DataWidth-1:0] rd_data_pn_q [MidDepth];
            logic [DataWidth-1:0] rd_data_pn_d [MidDepth];

            // Shift the middle stages. The data in a stage moves only when a valid entry arrives.
            always_comb begin
                rd_vld_pn_d[0]  = rd_vld_p0;
                rd_data_pn_d[0] = rd_vld_p0 ? rd_data_p0 : rd_data_pn_q[0];
                for (int i = 1; i < MidDepth; i++) begin
                    rd_vld_pn_d[i]  = rd_vld_pn_q[i-1];
                    rd_data_pn_d[i] = rd_vld_pn_q[i-1] ? rd_data_pn_q[i-1] : rd_data_pn_q[i];
                end
            end

            // Middle-stage valids. Reset drops the reads in flight.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_vld_pn_q <= '0;
                end else begin
                    rd_vld_pn_q <= rd_vld_pn_d;
                end
            end

            // Middle-stage data. There is no reset because it is qualified by the valids.
            always_ff @(posedge clk) begin
                for (int i = 0; i < MidDepth; i++) begin
                    rd_data_pn_q[i] <= rd_data_pn_d[i];
                end
            end

            assign tail_vld  = rd_vld_pn_q[MidDepth-1];
            assign tail_data = rd_data_pn_q[MidDepth-1];
        end else begin : g_direct
            assign tail_vld  = rd_vld_p0;
            assign tail_data = rd_data_p0;
        end
    endgenerate

    // Output stage. q holds its last value while no result arrives.
    always_comb begin
        q_valid_d = tail_vld;
        q_d       = tail_vld ? tail_data : q_q;
    end

    // Output registers. They clear asynchronously so that reset hides in-flight data at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_valid_q <= 1'b0;
            q_q       <= '0;
        end else begin
            q_valid_q <= q_valid_d;
            q_q       <= q_d;
        end
    end

    assign mem_if.q         = q_q;
    assign mem_if.q_valid   = q_valid_q;
    assign mem_if.init_done = init_done_q;
    assign mem_if.oob_err   = oob_err_q;

endmodule
